dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
Shares the single data-memory port between two requesters: the CPU M-stage store/load path (port C, fed by the store byte-enable/wdata formatter) and a DMA/debug master (port D). It arbitrates round-robin and sequences one transaction at a time against a variable-latency memory with a ready handshake. It also returns read data and a one-cycle done pulse to the winner, and flags memory timeouts.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)
TIMEOUT, 15, max ACCESS cycles without m_ready before abort (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
c_req  in  1  CPU request
c_we  in  1  CPU write (1) / read (0)
c_addr  in  ADDR_W  CPU address
c_wdata  in  DATA_W  CPU write data, pre-aligned
c_byteen  in  DATA_W/8  CPU byte enables
c_rdata  out  DATA_W  CPU read data
c_done  out  1  CPU transaction complete pulse
d_req, d_we, d_addr, d_wdata, d_byteen, d_rdata, d_done  same as C, for DMA
m_req  out  1  memory access strobe
m_we  out  1  memory write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_byteen  out  DATA_W/8  memory byte enables
m_rdata  in  DATA_W  memory read data
m_ready  in  1  memory completes access this cycle
busy  out  1  arbiter not IDLE
err  out  1  one-cycle pulse: transaction aborted by timeout

Behaviour:
- reset low (async): state IDLE; all outputs 0; last_grant=D (so C wins first tie); wait counter 0; latched fields 0. Deassertion is synchronous to clk.
- States: IDLE, ACCESS, RESP.
- IDLE: requests are sampled only here.
  - Only one request high: grant it.
  - Both high: grant the one not equal to last_grant.
  - On grant: latch we/addr/wdata/byteen of the winner; go ACCESS next cycle.
  - Exception: granted request is a write with byteen==0. Treat as no-op: go directly to RESP, no m_req, rdata=0.
- ACCESS:
  - m_req=1; m_we/m_addr/m_wdata/m_byteen driven from latched registers, stable all cycles.
  - Reads drive m_byteen = latched byteen unchanged.
  - m_ready=1: capture m_rdata (reads; 0 for writes); go RESP.
  - Counter increments each ACCESS cycle without m_ready. Reaching TIMEOUT without m_ready: go RESP with err=1 in RESP, rdata=0, m_req drops.
  - m_ready on the timeout cycle wins over timeout.
- RESP (exactly 1 cycle):
  - Winner's done=1; its rdata register updated and held until its next done.
  - Other port's done stays 0 and its rdata is unchanged.
  - last_grant := winner; counter cleared; return IDLE.
- Latency: request seen in IDLE at cycle N, m_req at N+1, m_ready at N+1 gives done at N+2. Each wait state adds 1. Back-to-back throughput is 1 transaction per 3 cycles minimum.
- Requester changes or drops req during ACCESS: ignored; latched transaction completes and done still pulses. req still high in the IDLE after RESP starts a new transaction (subject to round-robin).
- m_ready in IDLE/RESP: ignored.
- busy=1 in ACCESS and RESP.
- Reset asserted mid-ACCESS: immediate abort, m_req=0, no done or err pulse; memory side must tolerate a dropped strobe.
- No combinational path from any c_/d_ input to m_ outputs. m_ outputs are register-driven only.

Test Plan:
- CPU sw alone: c_req=1, we=1, addr=0x10, wdata=0x12345678, byteen=1111, m_ready tied 1 -> m_req at N+1 with those values; c_done at N+2; d_done stays 0.
- Concurrent after reset: c_req and d_req held high, m_ready=1 -> grants alternate C, D, C, D; done pulses every 3 cycles.
- Wait states: D read addr=0x40, m_ready asserted on 4th ACCESS cycle with m_rdata=0xCAFEBABE -> m_req high 4 cycles with stable fields; d_done at N+5; d_rdata=0xCAFEBABE and held afterwards.
- Timeout (TIMEOUT=15): m_ready never asserted -> m_req high 15 cycles; then err and c_done pulse together; c_rdata=0. Repeat with m_ready on the 15th cycle -> no err.
- No-op write: c_we=1, byteen=0000 -> m_req never asserts; c_done at N+1.
- Reset mid-ACCESS: assert reset on ACCESS cycle 2 -> m_req, busy go 0 immediately; no done or err. After release, a tie goes to C.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (port C)
// and a DMA/debug master (port D), one transaction at a time, with timeout.
module dm_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_byteen,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_done,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byteen,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_byteen,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic                busy,
    output logic                err
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_reg, state_next;
    logic                win_reg, win_next;     // 0 = C, 1 = D
    logic                last_reg, last_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [BE_W-1:0]     be_reg, be_next;
    logic                m_req_reg, m_req_next;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   c_rdata_reg, c_rdata_next;
    logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
    logic                grant_d;
    logic                resp_load;
    logic [DATA_W-1:0]   resp_data;
    logic [1:0]          done_vec;

    always_comb begin
        state_next   = state_reg;
        win_next     = win_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        be_next      = be_reg;
        m_req_next   = m_req_reg;
        err_next     = err_reg;
        c_rdata_next = c_rdata_reg;
        d_rdata_next = d_rdata_reg;
        grant_d      = 1'b0;
        resp_load    = 1'b0;
        resp_data    = '0;

        case (state_reg)
            IDLE: begin
                if (c_req || d_req) begin
                    // On a tie, D wins only if C was served last
                    grant_d    = d_req && (!c_req || !last_reg);
                    win_next   = grant_d;
                    we_next    = grant_d ? d_we     : c_we;
                    addr_next  = grant_d ? d_addr   : c_addr;
                    wdata_next = grant_d ? d_wdata  : c_wdata;
                    be_next    = grant_d ? d_byteen : c_byteen;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    if (we_next && (be_next == '0)) begin
                        state_next = RESP;
                        resp_load  = 1'b1;
                    end else begin
                        state_next = ACCESS;
                        m_req_next = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (m_ready) begin
                    state_next = RESP;
                    m_req_next = 1'b0;
                    resp_load  = 1'b1;
                    resp_data  = we_reg ? '0 : m_rdata;
                end else if (cnt_reg == TO_LAST) begin
                    state_next = RESP;
                    m_req_next = 1'b0;
                    err_next   = 1'b1;
                    resp_load  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
                last_next  = win_reg;
                cnt_next   = '0;
                err_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase

        if (resp_load) begin
            if (win_next) d_rdata_next = resp_data;
            else          c_rdata_next = resp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            win_reg     <= 1'b0;
            last_reg    <= 1'b1;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            m_req_reg   <= 1'b0;
            err_reg     <= 1'b0;
            c_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            win_reg     <= win_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            be_reg      <= be_next;
            m_req_reg   <= m_req_next;
            err_reg     <= err_next;
            c_rdata_reg <= c_rdata_next;
            d_rdata_reg <= d_rdata_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_done
            assign done_vec[gi] = (state_reg == RESP) && (win_reg == 1'(gi));
        end
    endgenerate

    // Memory side comes straight from the latched transaction registers
    assign m_req    = m_req_reg;
    assign m_we     = we_reg;
    assign m_addr   = addr_reg;
    assign m_wdata  = wdata_reg;
    assign m_byteen = be_reg;
    assign c_rdata  = c_rdata_reg;
    assign d_rdata  = d_rdata_reg;
    assign c_done   = done_vec[0];
    assign d_done   = done_vec[1];
    assign busy     = (state_reg != IDLE);
    assign err      = err_reg;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_dm_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, c_done;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0, c_rdata;
    logic [BW-1:0] c_byteen = '0;
    logic          d_req = 1'b0, d_we = 1'b0, d_done;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata;
    logic [BW-1:0] d_byteen = '0;
    logic          m_req, m_we, m_ready = 1'b0, busy, err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata = '0;
    logic [BW-1:0] m_byteen;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who was served last, and each port's held read data
    bit            last_d;
    logic [DW-1:0] c_rd_m, d_rd_m;

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_byteen(c_byteen), .c_rdata(c_rdata), .c_done(c_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteen(d_byteen), .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .m_rdata(m_rdata), .m_ready(m_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        c_req = 1'b0; d_req = 1'b0; m_ready = 1'b1;
        c_addr = $urandom; d_addr = $urandom;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({m_req, busy, c_done, d_done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {m_req, busy, c_done, d_done, err});
        end
        n_tests++;
        if ({c_rdata, d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", c_rdata, d_rdata);
        end
        n_tests++;
        if ({m_we, m_addr, m_wdata, m_byteen} !== '0) begin
            n_fail++;
            $display("FAIL reset_mfields: got we=%b addr=%h wdata=%h be=%h want all 0",
                     m_we, m_addr, m_wdata, m_byteen);
        end
        reset = 1'b1;
        m_ready = 1'b0;
        last_d = 1'b1; c_rd_m = '0; d_rd_m = '0;
        step;
    endtask

    task automatic test_cpu_sw;
        c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h12345678; c_byteen = 4'hF;
        m_ready = 1'b1; c_req = 1'b1;
        step;
        c_req = 1'b0;
        n_tests++;
        if ({m_req, m_we, m_addr, m_wdata, m_byteen} !== {1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF}) begin
            n_fail++;
            $display("FAIL cpu_sw_access: got req=%b we=%b addr=%h wdata=%h be=%h want 1 1 00000010 12345678 f",
                     m_req, m_we, m_addr, m_wdata, m_byteen);
        end
        step;
        n_tests++;
        if ({c_done, d_done, err, busy} !== 4'b1001 || c_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL cpu_sw_done: got c_done=%b d_done=%b err=%b busy=%b c_rdata=%h want 1 0 0 1 0",
                     c_done, d_done, err, busy, c_rdata);
        end
        step;
        n_tests++;
        if ({c_done, busy, m_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL cpu_sw_idle: got c_done=%b busy=%b m_req=%b want 000", c_done, busy, m_req);
        end
        last_d = 1'b0; c_rd_m = '0;
        $display("[TB] txn cpu_sw port=C we=1 addr=00000010");
        m_ready = 1'b0;
    endtask

    task automatic test_concurrent;
        logic [DW-1:0] rv;
        bit exp_d;
        reset = 1'b0;
        step;
        reset = 1'b1;
        last_d = 1'b1; c_rd_m = '0; d_rd_m = '0;
        c_we = 1'b0; d_we = 1'b0; c_byteen = 4'hF; d_byteen = 4'h3;
        c_addr = $urandom; d_addr = $urandom;
        c_req = 1'b1; d_req = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_d = !last_d;
            rv = $urandom;
            m_rdata = rv;
            step;
            n_tests++;
            if (m_req !== 1'b1 || m_addr !== (exp_d ? d_addr : c_addr)) begin
                n_fail++;
                $display("FAIL concurrent_grant[%0d]: got req=%b addr=%h want 1 %h",
                         k, m_req, m_addr, exp_d ? d_addr : c_addr);
            end
            step;
            if (exp_d) d_rd_m = rv; else c_rd_m = rv;
            n_tests++;
            if ({c_done, d_done} !== {!exp_d, exp_d} || {c_rdata, d_rdata} !== {c_rd_m, d_rd_m}) begin
                n_fail++;
                $display("FAIL concurrent_done[%0d]: got done=%b%b rdata=%h/%h want %b%b %h/%h",
                         k, c_done, d_done, c_rdata, d_rdata, !exp_d, exp_d, c_rd_m, d_rd_m);
            end
            $display("[TB] txn concurrent[%0d] port=%s rdata=%h", k, exp_d ? "D" : "C", rv);
            last_d = exp_d;
            c_addr = $urandom; d_addr = $urandom;
            step;
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL concurrent_idle[%0d]: got busy=%b want 0", k, busy);
            end
        end
        c_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        step;
    endtask

    task automatic test_wait_states;
        d_we = 1'b0; d_addr = 32'h40; d_byteen = 4'hF; d_req = 1'b1; m_ready = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            step;
            d_req = 1'b0;
            n_tests++;
            if ({m_req, m_we, m_addr, m_byteen} !== {1'b1, 1'b0, 32'h40, 4'hF} || d_done !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_access[%0d]: got req=%b we=%b addr=%h be=%h d_done=%b want 1 0 00000040 f 0",
                         cyc, m_req, m_we, m_addr, m_byteen, d_done);
            end
            m_ready = (cyc == 4);
            m_rdata = (cyc == 4) ? 32'hCAFEBABE : $urandom;
        end
        step;
        m_ready = 1'b0;
        d_rd_m = 32'hCAFEBABE;
        n_tests++;
        if ({d_done, c_done, err, m_req} !== 4'b1000 || d_rdata !== 32'hCAFEBABE || c_rdata !== c_rd_m) begin
            n_fail++;
            $display("FAIL wait_done: got d_done=%b c_done=%b err=%b m_req=%b d_rdata=%h c_rdata=%h want 1 0 0 0 cafebabe %h",
                     d_done, c_done, err, m_req, d_rdata, c_rdata, c_rd_m);
        end
        last_d = 1'b1;
        $display("[TB] txn wait_states port=D addr=00000040 rdata=%h", d_rdata);
        step;
        step;
        n_tests++;
        if (d_done !== 1'b0 || d_rdata !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL wait_hold: got d_done=%b d_rdata=%h want 0 cafebabe", d_done, d_rdata);
        end
    endtask

    task automatic test_timeout;
        logic [DW-1:0] rv;
        for (int pass = 0; pass < 2; pass++) begin
            rv = $urandom | 32'h1;
            c_we = 1'b0; c_addr = $urandom; c_byteen = 4'hF; c_req = 1'b1; m_ready = 1'b0;
            for (int cyc = 1; cyc <= TO; cyc++) begin
                step;
                c_req = 1'b0;
                n_tests++;
                if (m_req !== 1'b1 || err !== 1'b0 || c_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_access[%0d.%0d]: got m_req=%b err=%b c_done=%b want 1 0 0",
                             pass, cyc, m_req, err, c_done);
                end
                m_ready = (pass == 1) && (cyc == TO);
                m_rdata = rv;
            end
            step;
            m_ready = 1'b0;
            c_rd_m = (pass == 1) ? rv : '0;
            n_tests++;
            if ({c_done, err, d_done, m_req} !== {1'b1, pass == 0, 1'b0, 1'b0} || c_rdata !== c_rd_m) begin
                n_fail++;
                $display("FAIL timeout_resp[%0d]: got c_done=%b err=%b d_done=%b m_req=%b c_rdata=%h want 1 %b 0 0 %h",
                         pass, c_done, err, d_done, m_req, c_rdata, pass == 0, c_rd_m);
            end
            last_d = 1'b0;
            $display("[TB] txn timeout[%0d] port=C err=%b rdata=%h", pass, err, c_rdata);
            step;
            n_tests++;
            if ({err, c_done, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL timeout_after[%0d]: got err=%b c_done=%b busy=%b want 000", pass, err, c_done, busy);
            end
        end
    endtask

    task automatic test_noop;
        c_we = 1'b1; c_byteen = 4'h0; c_addr = $urandom; c_wdata = $urandom;
        m_ready = 1'b1; c_req = 1'b1;
        step;
        c_req = 1'b0;
        c_rd_m = '0;
        n_tests++;
        if ({m_req, c_done, d_done, err, busy} !== 5'b01001 || c_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL noop_resp: got m_req=%b c_done=%b d_done=%b err=%b busy=%b c_rdata=%h want 0 1 0 0 1 0",
                     m_req, c_done, d_done, err, busy, c_rdata);
        end
        last_d = 1'b0;
        $display("[TB] txn noop port=C we=1 be=0");
        step;
        n_tests++;
        if ({m_req, c_done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL noop_after: got m_req=%b c_done=%b busy=%b want 000", m_req, c_done, busy);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] rv;
        c_we = 1'b0; c_byteen = 4'hF; c_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        d_we = 1'b0; d_byteen = 4'hF; m_ready = 1'b0; c_req = 1'b1;
        step;
        step;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({m_req, busy, c_done, d_done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got %b want 00000", {m_req, busy, c_done, d_done, err});
        end
        step;
        n_tests++;
        if ({m_req, busy, c_done, d_done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_held: got %b want 00000", {m_req, busy, c_done, d_done, err});
        end
        d_req = 1'b1;
        reset = 1'b1;
        last_d = 1'b1; c_rd_m = '0; d_rd_m = '0;
        step;
        c_req = 1'b0; d_req = 1'b0;
        n_tests++;
        if (m_req !== 1'b1 || m_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL reset_mid_tie: got m_req=%b addr=%h want 1 00000100", m_req, m_addr);
        end
        rv = $urandom;
        m_rdata = rv; m_ready = 1'b1;
        step;
        m_ready = 1'b0;
        c_rd_m = rv;
        n_tests++;
        if ({c_done, d_done, err} !== 3'b100 || {c_rdata, d_rdata} !== {c_rd_m, d_rd_m}) begin
            n_fail++;
            $display("FAIL reset_mid_done: got done=%b%b err=%b rdata=%h/%h want 10 0 %h/%h",
                     c_done, d_done, err, c_rdata, d_rdata, c_rd_m, d_rd_m);
        end
        last_d = 1'b0;
        $display("[TB] txn reset_mid port=C rdata=%h", c_rdata);
        step;
    endtask

    task automatic test_random;
        int sel, w, n_acc;
        bit exp_d, noop, tmo;
        logic          we_e;
        logic [AW-1:0] addr_e;
        logic [DW-1:0] wdata_e, rv, rd_e;
        logic [BW-1:0] be_e;
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(1, 3);
            c_we = 1'($urandom); d_we = 1'($urandom);
            c_addr = $urandom; d_addr = $urandom; c_wdata = $urandom; d_wdata = $urandom;
            c_byteen = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            d_byteen = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            w = $urandom_range(0, TO + 1);
            rv = $urandom;
            exp_d = (sel == 2) || (sel == 3 && !last_d);
            we_e    = exp_d ? d_we : c_we;
            addr_e  = exp_d ? d_addr : c_addr;
            wdata_e = exp_d ? d_wdata : c_wdata;
            be_e    = exp_d ? d_byteen : c_byteen;
            noop  = we_e && (be_e == 4'h0);
            tmo   = !noop && (w >= TO);
            n_acc = noop ? 0 : (tmo ? TO : w + 1);
            c_req = (sel != 2); d_req = (sel != 1);
            m_ready = 1'($urandom);
            for (int cyc = 1; cyc <= n_acc; cyc++) begin
                step;
                if (cyc == 1) begin
                    c_req = 1'b0; d_req = 1'b0;
                    c_addr = $urandom; d_addr = $urandom; c_wdata = $urandom; d_byteen = 4'($urandom);
                end
                n_tests++;
                if ({m_req, m_we, m_addr, m_wdata, m_byteen} !== {1'b1, we_e, addr_e, wdata_e, be_e}) begin
                    n_fail++;
                    $display("FAIL rand_access[%0d.%0d]: got req=%b we=%b addr=%h wdata=%h be=%h want 1 %b %h %h %h",
                             k, cyc, m_req, m_we, m_addr, m_wdata, m_byteen, we_e, addr_e, wdata_e, be_e);
                end
                m_ready = !tmo && (cyc == n_acc);
                m_rdata = (cyc == n_acc) ? rv : $urandom;
            end
            step;
            c_req = 1'b0; d_req = 1'b0;
            rd_e = (noop || tmo || we_e) ? '0 : rv;
            if (exp_d) d_rd_m = rd_e; else c_rd_m = rd_e;
            n_tests++;
            if ({c_done, d_done, err, m_req} !== {!exp_d, exp_d, tmo, 1'b0} || {c_rdata, d_rdata} !== {c_rd_m, d_rd_m}) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got done=%b%b err=%b m_req=%b rdata=%h/%h want %b%b %b 0 %h/%h",
                         k, c_done, d_done, err, m_req, c_rdata, d_rdata, !exp_d, exp_d, tmo, c_rd_m, d_rd_m);
            end
            $display("[TB] txn rand[%0d] port=%s we=%b be=%h wait=%0d noop=%b timeout=%b",
                     k, exp_d ? "D" : "C", we_e, be_e, w, noop, tmo);
            last_d = exp_d;
            m_ready = 1'($urandom);
            step;
            n_tests++;
            if ({busy, c_done, d_done, err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rand_idle[%0d]: got busy=%b done=%b%b err=%b want 0000", k, busy, c_done, d_done, err);
            end
            m_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_cpu_sw;
        test_concurrent;
        test_wait_states;
        test_timeout;
        test_noop;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
